mul_tree_arb: RTL and testbench

Arbiter and sequencer that shares one `mul_tree_bf16` multiplier tree between NREQ requesters. It accepts operand bundles tagged with a tree mode and issues them to the tree one per cycle, round-robin among requesters. Mode changes happen only after the tree pipeline has fully drained. Each tree result is returned to the requester that issued the bundle. The block sits between the node-level request sources and the tree instance.

---
 rtl/mul_arb_pkg.sv | 19 +
 rtl/mul_tree_arb_tag_fifo.sv | 53 +++++
 rtl/mul_tree_arb.sv | 217 +++++++++++++++++++++
 tb/tb_mul_tree_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the mul_tree_arb block:
// arbiter state encoding, tree mode values and operand bundle width.
package mul_arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DRAIN  = 2'b01,
      ST_SWITCH = 2'b10
   } state_t;

   localparam logic [1:0] MODE_0 = 2'b00;
   localparam logic [1:0] MODE_1 = 2'b01;
   localparam logic [1:0] MODE_2 = 2'b10;
   localparam logic [1:0] MODE_3 = 2'b11;

   // Four 32-bit operand pairs per bundle.
   localparam int BUNDLE_W = 128;

endpackage

// File: rtl/mul_tree_arb_tag_fifo.sv
// tag_fifo: small synchronous FIFO holding the requester index of each
// bundle in flight through the tree. Occupancy always equals the arbiter's
// in-flight count, so empty/full double as count==0 / count==DEPTH.
module tag_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   input  logic         i_flush,
   output logic [W-1:0] o_dout,
   output logic         o_empty,
   output logic         o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

   // Tag storage write.
   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, so clearing the array would only cost flops.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

   // Read/write pointers; a flush drops every stored tag at once.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/mul_tree_arb.sv
// mul_tree_arb: shares one mul_tree_bf16 tree between NREQ requesters.
// Round-robin grants within the current tree mode, drains the tree before
// any mode change, and routes each in-order tree result back to its issuer.
// Optional watchdog: define MUL_ARB_WDOG_EN to flush a stalled tree after
// TIMEOUT cycles without a completion.
module mul_tree_arb
   import mul_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int DW      = 16,
   parameter int DEPTH   = 8,
   parameter int BURST   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [2*NREQ-1:0]          req_mode,
   input  logic [BUNDLE_W*NREQ-1:0]   req_data,
   output logic [BUNDLE_W-1:0]        tree_ins,
   output logic                       tree_stb,
   output logic [1:0]                 tree_mode,
   input  logic [4*DW-1:0]            tree_out,
   input  logic [3:0]                 tree_out_stb,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [4*DW-1:0]            rsp_data,
   output logic [3:0]                 rsp_stb,
   output logic                       busy,
   output logic                       err
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(BURST + 1);

   state_t                r_state, w_state_next;
   logic [1:0]            r_cur_mode, r_target_mode;
   logic [CW-1:0]         r_count, w_cnt_after_cpl;
   logic [IW-1:0]         r_rr_ptr;
   logic [BW-1:0]         r_burst_cnt;
   logic                  r_err;
   logic                  r_tree_stb;
   logic [BUNDLE_W-1:0]   r_tree_ins;
   logic [NREQ-1:0]       r_rsp_valid;
   logic [4*DW-1:0]       r_rsp_data;
   logic [3:0]            r_rsp_stb;

   logic                  w_grant_found, w_mis_found;
   logic [IW-1:0]         w_grant_idx;
   logic [1:0]            w_target_mode;
   logic [BUNDLE_W-1:0]   w_sel_data;
   logic                  w_issue, w_enter_drain, w_leave_drain, w_drained;
   logic                  w_cpl, w_cpl_ok, w_spurious, w_wdog_fire;
   logic                  w_fifo_empty, w_fifo_full;
   logic [IW-1:0]         w_fifo_head;

   // Completion bookkeeping; an empty tag FIFO means nothing is in flight.
   assign w_cpl           = |tree_out_stb;
   assign w_cpl_ok        = w_cpl && !w_fifo_empty;
   assign w_spurious      = w_cpl && w_fifo_empty;
   assign w_cnt_after_cpl = r_count - CW'(w_cpl_ok);
   assign w_drained       = (w_cnt_after_cpl == '0) || w_wdog_fire;

   // Round-robin scan from the pointer: first same-mode requester to grant,
   // first other-mode requester to pick the next tree mode.
   // NOTE: every combinational output gets a default before any branch so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      int idx;
      idx           = 0;
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_sel_data    = '0;
      w_mis_found   = 1'b0;
      w_target_mode = r_cur_mode;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[idx]) begin
            if (req_mode[2*idx +: 2] == r_cur_mode) begin
               if (!w_grant_found) begin
                  w_grant_found = 1'b1;
                  w_grant_idx   = IW'(idx);
                  w_sel_data    = req_data[BUNDLE_W*idx +: BUNDLE_W];
               end
            end else if (!w_mis_found) begin
               w_mis_found   = 1'b1;
               w_target_mode = req_mode[2*idx +: 2];
            end
         end
      end
   end

   // Next-state and issue decision.
   always_comb begin
      w_state_next  = r_state;
      w_issue       = 1'b0;
      w_enter_drain = 1'b0;
      w_leave_drain = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_mis_found && (!w_grant_found || r_burst_cnt == BW'(BURST))) begin
               w_state_next  = ST_DRAIN;
               w_enter_drain = 1'b1;
            end else if (w_grant_found && r_count < CW'(DEPTH) &&
                         !w_fifo_full && !w_wdog_fire) begin
               w_issue = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (w_drained) begin
               w_state_next  = ST_SWITCH;
               w_leave_drain = 1'b1;
            end
         end
         ST_SWITCH: w_state_next = ST_RUN;
         default:   w_state_next = ST_RUN;
      endcase
   end

   // One-hot grant toward the selected requester.
   always_comb begin
      req_ready = '0;
      if (w_issue) req_ready[w_grant_idx] = 1'b1;
   end

   // Control state: FSM, mode, in-flight count, pointer, burst, error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_RUN;
         r_cur_mode    <= MODE_0;
         r_target_mode <= MODE_0;
         r_count       <= '0;
         r_rr_ptr      <= '0;
         r_burst_cnt   <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_enter_drain) r_target_mode <= w_target_mode;
         if (w_leave_drain) r_cur_mode    <= r_target_mode;
         if (w_wdog_fire) r_count <= '0;
         else             r_count <= w_cnt_after_cpl + CW'(w_issue);
         if (w_issue)
            r_rr_ptr <= (w_grant_idx == IW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
         if (r_state == ST_SWITCH)
            r_burst_cnt <= '0;
         else if (w_issue && r_burst_cnt != BW'(BURST))
            r_burst_cnt <= r_burst_cnt + 1'b1;
         if (w_spurious || w_wdog_fire) r_err <= 1'b1;
      end
   end

   // Registered tree issue and one-cycle response pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tree_stb  <= 1'b0;
         r_tree_ins  <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_stb   <= '0;
      end else begin
         r_tree_stb  <= w_issue;
         if (w_issue) r_tree_ins <= w_sel_data;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_stb   <= '0;
         if (w_cpl_ok) begin
            r_rsp_valid[w_fifo_head] <= 1'b1;
            r_rsp_data               <= tree_out;
            r_rsp_stb                <= tree_out_stb;
         end
      end
   end

`ifdef MUL_ARB_WDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] r_wdog_cnt;

   assign w_wdog_fire = (r_count != '0) && !w_cpl_ok &&
                        (r_wdog_cnt == WW'(TIMEOUT - 1));

   // Stall counter: cycles with work in flight but no completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                         r_wdog_cnt <= '0;
      else if (r_count == '0 || w_cpl_ok || w_wdog_fire) r_wdog_cnt <= '0;
      else                                               r_wdog_cnt <= r_wdog_cnt + 1'b1;
   end
`else
   assign w_wdog_fire = 1'b0;
`endif

   tag_fifo #(
      .DEPTH (DEPTH),
      .W     (IW)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_issue),
      .i_din   (w_grant_idx),
      .i_pop   (w_cpl_ok),
      .i_flush (w_wdog_fire),
      .o_dout  (w_fifo_head),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign tree_stb  = r_tree_stb;
   assign tree_ins  = r_tree_ins;
   assign tree_mode = r_cur_mode;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_stb   = r_rsp_stb;
   assign busy      = (r_count != '0) || (r_state != ST_RUN);
   assign err       = r_err;

endmodule

// File: tb/tb_mul_tree_arb.sv
// Testbench for mul_tree_arb: directed scenarios plus a randomized
// same-mode phase, checked against a queue-based model of issued tags.
module tb_mul_tree_arb;

   localparam int NREQ  = 2;
   localparam int DW    = 16;
   localparam int DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [2*NREQ-1:0]     req_mode;
   logic [128*NREQ-1:0]   req_data;
   logic [127:0]          tree_ins;
   logic                  tree_stb;
   logic [1:0]            tree_mode;
   logic [4*DW-1:0]       tree_out;
   logic [3:0]            tree_out_stb;
   logic [NREQ-1:0]       rsp_valid;
   logic [4*DW-1:0]       rsp_data;
   logic [3:0]            rsp_stb;
   logic                  busy;
   logic                  err;

   int           total = 0;
   int           bad   = 0;
   logic [127:0] hold_data [NREQ];
   int           q_tag [$];
   int           m_ptr  = 0;
   logic         m_err  = 1'b0;
   logic [1:0]   m_mode = 2'b00;

   always #5 clk = ~clk;

   mul_tree_arb #(
      .NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .BURST(8), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_mode(req_mode), .req_data(req_data),
      .tree_ins(tree_ins), .tree_stb(tree_stb), .tree_mode(tree_mode),
      .tree_out(tree_out), .tree_out_stb(tree_out_stb),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_stb(rsp_stb),
      .busy(busy), .err(err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // First valid requester at or after the model's round-robin pointer.
   function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] vld);
      logic [NREQ-1:0] pick;
      bit              found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_ptr + k) % NREQ;
         if (!found && vld[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

   // One clock cycle: drive inputs, check the grant, update the model,
   // then check the registered issue/response outputs after the edge.
   task automatic cyc(input logic [NREQ-1:0] vld, input logic [2*NREQ-1:0] mode,
                      input logic [3:0] cstb, input logic [NREQ-1:0] exp_rdy);
      logic [127:0]    exp_ins;
      logic [NREQ-1:0] exp_rsp;
      logic [63:0]     exp_rdata;
      int              g;
      int              t;
      req_valid = vld;
      req_mode  = mode;
      for (int i = 0; i < NREQ; i++) req_data[128*i +: 128] = hold_data[i];
      tree_out_stb = cstb;
      tree_out     = {$urandom, $urandom};
      #1;
      check("req_ready", req_ready, exp_rdy);
      exp_rsp   = '0;
      exp_rdata = '0;
      if (cstb != 4'b0000) begin
         if (q_tag.size() == 0) m_err = 1'b1;
         else begin
            t            = q_tag.pop_front();
            exp_rsp[t]   = 1'b1;
            exp_rdata    = tree_out;
         end
      end
      g       = -1;
      exp_ins = '0;
      for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) g = i;
      if (g >= 0) begin
         exp_ins = hold_data[g];
         q_tag.push_back(g);
         m_ptr = (g + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      check("tree_stb", tree_stb, (g >= 0) ? 128'd1 : 128'd0);
      if (g >= 0) begin
         check("tree_ins", tree_ins, exp_ins);
         hold_data[g] = rnd128();
      end
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != '0) begin
         check("rsp_data", rsp_data, exp_rdata);
         check("rsp_stb", rsp_stb, cstb);
      end
      check("err", err, m_err);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [NREQ-1:0] vld;
      logic [3:0]      cstb;
      rst          = 1'b0;
      req_valid    = '0;
      req_mode     = '0;
      req_data     = '0;
      tree_out     = '0;
      tree_out_stb = '0;
      for (int i = 0; i < NREQ; i++) hold_data[i] = rnd128();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_tree_stb", tree_stb, 0);
      check("rst_tree_ins", tree_ins, 0);
      check("rst_tree_mode", tree_mode, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_stb", rsp_stb, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      rst = 1'b1;

      // Single issue from requester 0, then its completion.
      cyc(2'b01, 4'b0000, 4'b0000, 2'b01);
      cyc(2'b00, 4'b0000, 4'b0000, 2'b00);
      check("busy_inflight", busy, 1);
      cyc(2'b00, 4'b0000, 4'b0101, 2'b00);
      check("busy_idle", busy, 0);

      // Round-robin: both requesters valid in the same mode.
      check("rr_first_is_1", rr_pick(2'b11), 2'b10);
      for (int k = 0; k < 4; k++) cyc(2'b11, 4'b0000, 4'b0000, rr_pick(2'b11));
      for (int k = 0; k < 4; k++) cyc(2'b00, 4'b0000, 4'b1111, 2'b00);

      // Mode switch: three bundles in flight, requester 1 wants mode 2'b10.
      for (int k = 0; k < 3; k++) cyc(2'b01, 4'b0000, 4'b0000, 2'b01);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      check("busy_drain", busy, 1);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0001, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0010, 2'b00);
      check("tree_mode_drain", tree_mode, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0100, 2'b00);
      check("tree_mode_switch", tree_mode, 2'b10);
      m_mode = 2'b10;
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b10);
      cyc(2'b00, 4'b1000, 4'b0001, 2'b00);

      // Full: DEPTH issues, then one completion frees exactly one slot.
      for (int k = 0; k < DEPTH; k++) cyc(2'b10, 4'b1000, 4'b0000, 2'b10);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0001, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b10);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      // Issue and completion together leave the count at DEPTH-1.
      cyc(2'b10, 4'b1000, 4'b0010, 2'b00);
      cyc(2'b10, 4'b1000, 4'b0100, 2'b10);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b10);
      cyc(2'b10, 4'b1000, 4'b0000, 2'b00);
      while (q_tag.size() > 0) cyc(2'b00, 4'b1000, 4'b1000, 2'b00);
      check("busy_after_full", busy, 0);

`ifdef MUL_ARB_WDOG_EN
      // Watchdog: one issue that never completes.
      cyc(2'b10, 4'b1010, 4'b0000, rr_pick(2'b10));
      for (int k = 0; k < 63; k++) cyc(2'b00, 4'b1010, 4'b0000, 2'b00);
      m_err = 1'b1;
      q_tag.delete();
      cyc(2'b00, 4'b1010, 4'b0000, 2'b00);
      check("wdog_busy", busy, 0);
      cyc(2'b10, 4'b1010, 4'b0000, rr_pick(2'b10));
      cyc(2'b00, 4'b1010, 4'b0001, 2'b00);
`endif

      // Spurious completion with nothing in flight.
      cyc(2'b00, 4'b1000, 4'b0010, 2'b00);
      check("err_sticky", err, 1);

      // Randomized traffic in the current mode.
      for (int n = 0; n < 60; n++) begin
         vld  = NREQ'($urandom_range(0, 3));
         cstb = (q_tag.size() > 0 && $urandom_range(0, 1) == 1) ?
                4'($urandom_range(1, 15)) : 4'b0000;
         cyc(vld, {m_mode, m_mode}, cstb,
             (q_tag.size() < DEPTH) ? rr_pick(vld) : '0);
      end
      while (q_tag.size() > 0) cyc(2'b00, {m_mode, m_mode}, 4'b0001, 2'b00);
      check("busy_end", busy, 0);
      check("tree_mode_end", tree_mode, m_mode);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
